// File: rtl/seq_mult_controller.sv
// -----------------------------------------------------------------------------
// seq_mult_controller
//
// Control and accumulate stage of a shift-and-add sequential multiplier. It
// drives the load/shift/ready inputs of two external shift registers (a
// 2W-bit left-shifting multiplicand register and a W-bit right-shifting
// multiplier register), consumes their outputs each cycle and accumulates the
// 2W-bit product. A start/done handshake frames each multiplication.
//
// Optional feature (compile-time macro):
//   EARLY_TERM_EN  - when defined, a RUN cycle that sees multiplierZero=1 ends
//                    the run early (no shift, no add that cycle). When
//                    undefined, multiplierZero is ignored and every run lasts
//                    exactly WORD_LENGTH cycles.
//
// Parameters:
//   WORD_LENGTH     operand width W; product/multiplicand path is 2W
//
// Ports:
//   clk             in   1   clock, all logic on posedge
//   reset           in   1   synchronous, active-high
//   start           in   1   request a new multiplication (sampled in IDLE)
//   multiplicandIn  in   2W  parallel output of the multiplicand register
//   multiplierLsb   in   1   bit 0 of the multiplier register
//   multiplierZero  in   1   multiplier register currently holds zero
//   loadRegs        out  1   load both shift registers
//   shiftRegs       out  1   shift both shift registers
//   readyOut        out  1   ready to the shift registers (mirrors done)
//   busy            out  1   high in LOAD and RUN
//   done            out  1   one-cycle pulse, product valid
//   product         out  2W  accumulated product
// -----------------------------------------------------------------------------
module seq_mult_controller #(
  parameter int WORD_LENGTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [2*WORD_LENGTH-1:0]   multiplicandIn,
  input  logic                       multiplierLsb,
  input  logic                       multiplierZero,
  output logic                       loadRegs,
  output logic                       shiftRegs,
  output logic                       readyOut,
  output logic                       busy,
  output logic                       done,
  output logic [2*WORD_LENGTH-1:0]   product
);

  localparam int PW = 2 * WORD_LENGTH;
  localparam int CW = $clog2(WORD_LENGTH + 1);

  localparam logic [CW-1:0] COUNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] COUNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] COUNT_LAST = CW'(WORD_LENGTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   count_r;
  logic [PW-1:0]   product_r;
  logic            load_r;
  logic            shift_r;
  logic            busy_r;
  logic            done_r;
  logic            early_stop_s;

`ifdef EARLY_TERM_EN
  // A zero multiplier means every remaining partial product is zero, so the
  // run can end now without changing the result.
  assign early_stop_s = (state_r == RUN) && multiplierZero;
`else
  logic unused_multiplier_zero_s;
  assign early_stop_s             = 1'b0;
  assign unused_multiplier_zero_s = multiplierZero;
`endif

  // Control FSM, cycle counter and product accumulator. Control outputs are
  // registered as the decode of the state being entered, so they always match
  // the current state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      count_r   <= COUNT_ZERO;
      product_r <= {PW{1'b0}};
      load_r    <= 1'b0;
      shift_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r <= LOAD;
            load_r  <= 1'b1;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            load_r  <= 1'b0;
            busy_r  <= 1'b0;
          end
          shift_r <= 1'b0;
          done_r  <= 1'b0;
        end

        LOAD: begin
          state_r   <= RUN;
          count_r   <= COUNT_ZERO;
          product_r <= {PW{1'b0}};
          load_r    <= 1'b0;
          shift_r   <= 1'b1;
          busy_r    <= 1'b1;
          done_r    <= 1'b0;
        end

        RUN: begin
          load_r <= 1'b0;
          if (early_stop_s) begin
            // Nothing left to add; this cycle neither shifts nor accumulates.
            state_r <= DONE;
            shift_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            if (multiplierLsb) begin
              product_r <= product_r + multiplicandIn;
            end else begin
              product_r <= product_r;
            end
            count_r <= count_r + COUNT_ONE;
            // count is still the pre-increment value here, so the run covers
            // counts 0..W-1, i.e. exactly W cycles.
            if (count_r == COUNT_LAST) begin
              state_r <= DONE;
              shift_r <= 1'b0;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              state_r <= RUN;
              shift_r <= 1'b1;
              busy_r  <= 1'b1;
              done_r  <= 1'b0;
            end
          end
        end

        DONE: begin
          state_r <= IDLE;
          load_r  <= 1'b0;
          shift_r <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end

        default: begin
          state_r <= IDLE;
          count_r <= COUNT_ZERO;
          load_r  <= 1'b0;
          shift_r <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign loadRegs  = load_r;
  // The early-stop cycle must not shift: the zero flag is only known during
  // that cycle, so it gates the registered shift request directly.
  assign shiftRegs = shift_r & ~early_stop_s;
  assign readyOut  = done_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign product   = product_r;

endmodule

// File: tb/tb_seq_mult_controller.sv
// -----------------------------------------------------------------------------
// tb_seq_mult_controller
//
// Self-checking bench for seq_mult_controller. Models the two external shift
// registers, applies a table of directed vectors, hand-written reset and
// back-to-back sequences, and randomized operands checked against a reference
// built from plain arithmetic (a*b) and the expected run length.
// -----------------------------------------------------------------------------
module tb_seq_mult_controller;

  localparam int W  = 8;
  localparam int PW = 2 * W;

`ifdef EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          start;
  logic [PW-1:0] multiplicandIn;
  logic          multiplierLsb;
  logic          multiplierZero;
  logic          loadRegs;
  logic          shiftRegs;
  logic          readyOut;
  logic          busy;
  logic          done;
  logic [PW-1:0] product;

  // Environment shift registers and the operands they load.
  logic [PW-1:0] mcand_reg = '0;
  logic [W-1:0]  mplier_reg = '0;
  logic [W-1:0]  op_a = '0;
  logic [W-1:0]  op_b = '0;

  int passed = 0;
  int total  = 0;

  seq_mult_controller #(.WORD_LENGTH(W)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .multiplicandIn (multiplicandIn),
    .multiplierLsb  (multiplierLsb),
    .multiplierZero (multiplierZero),
    .loadRegs       (loadRegs),
    .shiftRegs      (shiftRegs),
    .readyOut       (readyOut),
    .busy           (busy),
    .done           (done),
    .product        (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (loadRegs) begin
      mcand_reg  <= {{W{1'b0}}, op_a};
      mplier_reg <= op_b;
    end else if (shiftRegs) begin
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
    end
  end

  assign multiplicandIn = mcand_reg;
  assign multiplierLsb  = mplier_reg[0];
  assign multiplierZero = (mplier_reg == '0);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else passed++;
  endtask

  // Reference: number of significant bits in the multiplier.
  function automatic int bit_len(input logic [W-1:0] v);
    int n = 0;
    logic [W-1:0] t = v;
    while (t != '0) begin
      n++;
      t = t >> 1;
    end
    return n;
  endfunction

  // With early termination the run ends one cycle after the last set bit
  // has been consumed, unless the full W cycles come first.
  function automatic int ref_done_cycle(input logic [W-1:0] b);
    int l = bit_len(b);
    int run_cycles = EARLY ? ((l == W) ? W : l + 1) : W;
    return run_cycles + 2;
  endfunction

  function automatic int ref_shifts(input logic [W-1:0] b);
    int l = bit_len(b);
    return EARLY ? l : W;
  endfunction

  // Watch one operation from the cycle after the start edge until done.
  task automatic monitor(input bit toggle, input bit hold, output bit got,
                         output int cyc, output int shifts, output int loads,
                         output int bad);
    got = 1'b0; cyc = 0; shifts = 0; loads = 0; bad = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (loadRegs) loads++;
      if (shiftRegs) shifts++;
      if (loadRegs && shiftRegs) bad++;
      if (readyOut !== done) bad++;
      if (done === 1'b1) begin
        got = 1'b1;
        cyc = c;
        if (busy !== 1'b0) bad++;
        if (!hold) start = 1'b0;
        break;
      end
      if (busy !== 1'b1) bad++;
      if (toggle && c >= 2) start = 1'($urandom_range(0, 1));
    end
  endtask

  // Must be called at a negedge while the DUT is in IDLE.
  task automatic run_and_check(input string tag, input logic [W-1:0] a,
                               input logic [W-1:0] b, input bit toggle,
                               input logic [PW-1:0] exp_prod, input int exp_done);
    bit got;
    int cyc, shifts, loads, bad;
    logic [PW-1:0] res;
    op_a = a;
    op_b = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    monitor(toggle, 1'b0, got, cyc, shifts, loads, bad);
    res = product;
    check({tag, "_done_seen"}, 64'(got), 64'd1);
    if (!got) begin
      $display("FAIL %s_timeout: no done within budget", tag);
      return;
    end
    check({tag, "_product"}, 64'(res), 64'(exp_prod));
    check({tag, "_done_cycle"}, 64'(cyc), 64'(exp_done));
    check({tag, "_shifts"}, 64'(shifts), 64'(ref_shifts(b)));
    check({tag, "_loads"}, 64'(loads), 64'd1);
    check({tag, "_ctrl_bad"}, 64'(bad), 64'd0);
    @(negedge clk);
    check({tag, "_pulse_end"}, {61'd0, done, busy, loadRegs}, 64'd0);
    check({tag, "_product_hold"}, 64'(product), 64'(res));
  endtask

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [PW-1:0] prod;
    int            done_off;
    int            done_on;
  } vec_t;

  vec_t vecs[8];

  initial begin
    bit got;
    int cyc, shifts, loads, bad, ndone;
    logic [W-1:0] ra, rb;

    vecs[0] = '{8'd13,  8'd11,  16'd143,   10, 7};
    vecs[1] = '{8'd255, 8'd255, 16'd65025, 10, 10};
    vecs[2] = '{8'd200, 8'd0,   16'd0,     10, 3};
    vecs[3] = '{8'd0,   8'd200, 16'd0,     10, 10};
    vecs[4] = '{8'd2,   8'd1,   16'd2,     10, 4};
    vecs[5] = '{8'd7,   8'd6,   16'd42,    10, 6};
    vecs[6] = '{8'd1,   8'd128, 16'd128,   10, 10};
    vecs[7] = '{8'd255, 8'd1,   16'd255,   10, 4};

    // Reset held with start high: nothing may launch.
    reset = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_load", 64'(loadRegs), 64'd0);
      check("reset_product", 64'(product), 64'd0);
    end
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {60'd0, busy, done, loadRegs, shiftRegs}, 64'd0);

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, 1'b0,
                    vecs[i].prod, EARLY ? vecs[i].done_on : vecs[i].done_off);
    end

    // Reset during a run aborts it without a done pulse.
    op_a = 8'd13;
    op_b = 8'd11;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_state", {60'd0, busy, done, loadRegs, shiftRegs}, 64'd0);
    check("abort_product", 64'(product), 64'd0);
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", 64'(ndone), 64'd0);
    run_and_check("restart", 8'd7, 8'd6, 1'b0, 16'd42, ref_done_cycle(8'd6));

    // start toggled while running must be ignored.
    run_and_check("toggle", 8'd13, 8'd11, 1'b1, 16'd143, ref_done_cycle(8'd11));

    // start held through DONE launches a second operation via IDLE.
    op_a = 8'd13;
    op_b = 8'd11;
    start = 1'b1;
    @(posedge clk);
    #1;
    monitor(1'b0, 1'b1, got, cyc, shifts, loads, bad);
    check("b2b_first_done", 64'(got), 64'd1);
    check("b2b_first_product", 64'(product), 64'd143);
    op_a = 8'd7;
    op_b = 8'd6;
    @(negedge clk);
    check("b2b_idle_gap", {62'd0, busy, loadRegs}, 64'd0);
    @(negedge clk);
    check("b2b_second_load", 64'(loadRegs), 64'd1);
    start = 1'b0;
    monitor(1'b0, 1'b0, got, cyc, shifts, loads, bad);
    check("b2b_second_done", 64'(got), 64'd1);
    check("b2b_second_product", 64'(product), 64'd42);
    check("b2b_second_cycle", 64'(cyc), 64'(ref_done_cycle(8'd6) - 1));
    @(negedge clk);

    // Randomized operands against a*b and the reference run length.
    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 255))
                                       : 8'($urandom_range(0, 15));
      run_and_check($sformatf("rand%0d", i), ra, rb, 1'($urandom_range(0, 1)),
                    16'(ra) * 16'(rb), ref_done_cycle(rb));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
